oc1_sweep_ctrl: RTL

//  Sequencer for one 3-input ones-counter datapath instance (inputs a,b,c; 2-bit count y1,y0).
//  On start, applies all 8 input vectors 3'b000..3'b111 in order and holds each for SETTLE_CYCLES

---
 rtl/oc1_sweep_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/oc1_sweep_ctrl.sv
// rtl/oc1_sweep_ctrl.sv - exhaustive 8-vector sweep sequencer for a 3-input ones-counter datapath
// Holds each vector for SETTLE_CYCLES clocks, then samples {y1,y0} against the popcount.
module oc1_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y1,
  input  logic       y0,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic [4:0] sum,
  output logic [3:0] err_cnt,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] sample;
  logic [1:0] expect_cnt;
  logic       mismatch;
  logic [3:0] err_next;

  always_comb begin
    sample     = {y1, y0};
    expect_cnt = {1'b0, vec_idx[2]} + {1'b0, vec_idx[1]} + {1'b0, vec_idx[0]};
    mismatch   = (sample != expect_cnt);
    err_next   = err_cnt + {3'b000, mismatch};
  end

  // The datapath inputs are the vector index bits straight from their flops.
  assign a = vec_idx[2];
  assign b = vec_idx[1];
  assign c = vec_idx[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vec_idx <= 3'd0;
      cnt     <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= 5'd0;
      err_cnt <= 4'd0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SETTLE;
            vec_idx <= 3'd0;
            cnt     <= 8'd0;
            sum     <= 5'd0;
            err_cnt <= 4'd0;
            pass    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == LAST_CNT) begin
            sum     <= sum + {3'b000, sample};
            err_cnt <= err_next;
            cnt     <= 8'd0;
            if (vec_idx == 3'd7) begin
              // Pass uses the count including this final sample.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 4'd0);
            end else begin
              vec_idx <= vec_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
